// File: rtl/ddr3_bank_fsm.sv
// Single-bank DDR3 command sequencer.
// Accepts front-end read/write requests and issues ACTIVATE / READ / WRITE / PRECHARGE
// commands to a downstream command generator over a valid/ready handshake, enforcing
// tRCD, tRP and tRAS spacing. It closes the bank on refresh_req and reports refresh_ack
// once the bank is precharged and idle.
//
// Build option: define DDR3_BANK_OPEN_PAGE_EN for the open-page policy, where the row is
// left open after an access and row hits skip ACTIVATE. When it is undefined, every
// access is closed with ACTIVATE-RW-PRECHARGE.
//
// Ports:
//   clk, rst                        clock, asynchronous active-high reset
//   req_valid/req_ready             front-end request handshake
//   req_write, req_row, req_col     request attributes (1 = write)
//   cmd_valid/cmd_ready             command handshake towards cmd_gen
//   cmd_type, cmd_addr              offered command and its address
//   refresh_req/refresh_ack         refresh pending / bank precharged and idle

package ddr3_bank_fsm_pkg;
  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_ACTIVATE  = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_PRECHARGE = 3'd4
  } ddr3_cmd_t;
endpackage

module ddr3_bank_fsm
  import ddr3_bank_fsm_pkg::*;
#(
  parameter int unsigned T_RCD = 5,
  parameter int unsigned T_RP  = 5,
  parameter int unsigned T_RAS = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [12:0] req_row,
  input  logic [9:0]  req_col,
  output logic        cmd_valid,
  output ddr3_cmd_t   cmd_type,
  output logic [12:0] cmd_addr,
  input  logic        cmd_ready,
  input  logic        refresh_req,
  output logic        refresh_ack
);

  // Counters are loaded with N-1 on the handshake so the gated command appears
  // exactly N cycles after that handshake cycle.
  localparam logic [3:0] TrcdLoad = 4'(T_RCD - 1);
  localparam logic [3:0] TrpLoad  = 4'(T_RP - 1);
  localparam logic [4:0] RasLoad  = 5'(T_RAS - 1);

  typedef enum logic [2:0] {
    StIdle, StAct, StTrcd, StRw, StActive, StPre, StTrp
  } state_e;

  state_e      state_q, state_d;
  logic        wr_q, wr_d;
  logic [12:0] row_q, row_d;
  logic [9:0]  col_q, col_d;
  logic        pend_q, pend_d;
  logic [12:0] open_row_q, open_row_d;
  logic        open_vld_q, open_vld_d;
  logic [3:0]  trcd_q, trcd_d;
  logic [3:0]  trp_q, trp_d;
  logic [4:0]  ras_q, ras_d;

  logic accept, hs, row_hit;

  assign accept  = req_valid && req_ready;
  assign hs      = cmd_valid && cmd_ready;
  assign row_hit = open_vld_q && (req_row == open_row_q);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StAct;
      StAct:    if (hs) state_d = StTrcd;
      StTrcd:   if (trcd_q <= 4'd1) state_d = StRw;
      StRw: begin
        if (hs) begin
`ifdef DDR3_BANK_OPEN_PAGE_EN
          // A refresh that arrived mid-access closes the bank straight away.
          state_d = refresh_req ? StPre : StActive;
`else
          state_d = StPre;
`endif
        end
      end
      StActive: begin
        if (refresh_req)  state_d = StPre;
        else if (accept) state_d = row_hit ? StRw : StPre;
      end
      StPre:    if (hs) state_d = StTrp;
      StTrp:    if (trp_q <= 4'd1) state_d = pend_q ? StAct : StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Outputs; rst gates the handshake outputs so they read 0 while reset is held.
  always_comb begin
    req_ready   = !rst && !refresh_req && (state_q == StIdle || state_q == StActive);
    refresh_ack = !rst && refresh_req && (state_q == StIdle);
    cmd_valid   = 1'b0;
    cmd_type    = CMD_NOP;
    cmd_addr    = 13'd0;
    unique case (state_q)
      StAct: begin
        cmd_valid = 1'b1;
        cmd_type  = CMD_ACTIVATE;
        cmd_addr  = row_q;
      end
      StRw: begin
        cmd_valid = 1'b1;
        cmd_type  = wr_q ? CMD_WRITE : CMD_READ;
        cmd_addr  = {3'b000, col_q};
      end
      StPre: begin
        if (ras_q == 5'd0) begin
          cmd_valid = 1'b1;
          cmd_type  = CMD_PRECHARGE;
        end
      end
      default: ;
    endcase
  end

  // Datapath next-state: request latch, open-row tracking, timing counters
  always_comb begin
    wr_d       = wr_q;
    row_d      = row_q;
    col_d      = col_q;
    pend_d     = pend_q;
    open_row_d = open_row_q;
    open_vld_d = open_vld_q;
    trcd_d     = (trcd_q == 4'd0) ? 4'd0 : trcd_q - 4'd1;
    trp_d      = (trp_q == 4'd0) ? 4'd0 : trp_q - 4'd1;
    ras_d      = (ras_q == 5'd0) ? 5'd0 : ras_q - 5'd1;
    if (accept) begin
      wr_d   = req_write;
      row_d  = req_row;
      col_d  = req_col;
      // Pending means an ACTIVATE is still owed; a row hit goes straight to RW.
      pend_d = (state_q == StIdle) || !row_hit;
    end
    if (state_q == StAct && hs) begin
      open_row_d = row_q;
      open_vld_d = 1'b1;
      pend_d     = 1'b0;
      trcd_d     = TrcdLoad;
      ras_d      = RasLoad;
    end
    if (state_q == StPre && hs) begin
      open_vld_d = 1'b0;
      trp_d      = TrpLoad;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q       <= 1'b0;
      row_q      <= 13'd0;
      col_q      <= 10'd0;
      pend_q     <= 1'b0;
      open_row_q <= 13'd0;
      open_vld_q <= 1'b0;
      trcd_q     <= 4'd0;
      trp_q      <= 4'd0;
      ras_q      <= 5'd0;
    end else begin
      wr_q       <= wr_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pend_q     <= pend_d;
      open_row_q <= open_row_d;
      open_vld_q <= open_vld_d;
      trcd_q     <= trcd_d;
      trp_q      <= trp_d;
      ras_q      <= ras_d;
    end
  end

endmodule

// File: tb/tb_ddr3_bank_fsm.sv
// Directed, scoreboard-checked bench for ddr3_bank_fsm (T_RCD=3, T_RP=3, T_RAS=8).
// Expected commands are queued with the stimulus; a negedge monitor pops them on
// every command handshake and checks type, address and cycle spacing.
module tb_ddr3_bank_fsm;
  import ddr3_bank_fsm_pkg::*;

  localparam int TRCD = 3;
  localparam int TRP  = 3;
  localparam int TRAS = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [12:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        cmd_ready = 1'b1;
  logic        refresh_req = 1'b0;
  logic        req_ready, cmd_valid, refresh_ack;
  ddr3_cmd_t   cmd_type;
  logic [12:0] cmd_addr;

  ddr3_bank_fsm #(.T_RCD(TRCD), .T_RP(TRP), .T_RAS(TRAS)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_row     (req_row),
    .req_col     (req_col),
    .cmd_valid   (cmd_valid),
    .cmd_type    (cmd_type),
    .cmd_addr    (cmd_addr),
    .cmd_ready   (cmd_ready),
    .refresh_req (refresh_req),
    .refresh_ack (refresh_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    ddr3_cmd_t   t;
    logic [12:0] a;
    int          gap;   // exact cycles since previous handshake; 0 = unchecked
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   last_hs = 0;
  int   last_act = -100;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input ddr3_cmd_t t, input logic [12:0] a, input int gap);
    exp_t e;
    e.t = t;
    e.a = a;
    e.gap = gap;
    sb.push_back(e);
  endtask

  // Command monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_cmd", 32'(cmd_type), 32'(CMD_NOP));
        end else begin
          mon_e = sb.pop_front();
          check("cmd_type", 32'(cmd_type), 32'(mon_e.t));
          check("cmd_addr", 32'(cmd_addr), 32'(mon_e.a));
          if (mon_e.gap != 0) check("cmd_gap", 32'(cyc - last_hs), 32'(mon_e.gap));
          if (mon_e.t == CMD_PRECHARGE) check("tras_min", 32'((cyc - last_act) >= TRAS), 32'd1);
          if (mon_e.t == CMD_ACTIVATE) last_act = cyc;
          last_hs = cyc;
        end
      end else if (!cmd_valid) begin
        check("nop_type", 32'(cmd_type), 32'(CMD_NOP));
        check("nop_addr", 32'(cmd_addr), 32'd0);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic w, input logic [12:0] row, input logic [9:0] col);
    bit ok;
    ok = 1'b0;
    req_write = w;
    req_row   = row;
    req_col   = col;
    req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    if (!ok) check("req_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_sb(input int n);
    for (int i = 0; i < 300 && sb.size() > n; i++) @(posedge clk);
    #1;
    check("sb_level", 32'(sb.size() <= n), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_refresh_ack"}, 32'(refresh_ack), 32'd0);
    check({tag, "_cmd_type"}, 32'(cmd_type), 32'(CMD_NOP));
    check({tag, "_cmd_addr"}, 32'(cmd_addr), 32'd0);
  endtask

  initial begin
    #200000;
    check("watchdog", 32'd0, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset: outputs quiet even with refresh_req high
    refresh_req = 1'b1;
    tick(2);
    check_reset_outputs("rst");
    refresh_req = 1'b0;
    #1;
    check("rst_req_ready_gated", 32'(req_ready), 32'd0);
    tick(1);
    rst = 1'b0;
    #1;
    check("idle_req_ready", 32'(req_ready), 32'd1);
    tick(2);

    // Read row 0x0A5 col 0x010: ACT at N, READ at N+3
    push(CMD_ACTIVATE, 13'h00A5, 0);
    push(CMD_READ, 13'h0010, TRCD);
`ifndef DDR3_BANK_OPEN_PAGE_EN
    push(CMD_PRECHARGE, 13'h0000, TRAS - TRCD);
`endif
    send_req(1'b0, 13'h00A5, 10'h010);
    wait_sb(0);
    tick(TRP + 1);

`ifdef DDR3_BANK_OPEN_PAGE_EN
    // Row hit: WRITE without ACTIVATE
    push(CMD_WRITE, 13'h03FF, 0);
    send_req(1'b1, 13'h00A5, 10'h3FF);
    wait_sb(0);
    // Row miss: PRE (tRAS honoured), ACT at PRE+3, READ at ACT+3
    push(CMD_PRECHARGE, 13'h0000, 0);
    push(CMD_ACTIVATE, 13'h0111, TRP);
    push(CMD_READ, 13'h0020, TRCD);
    send_req(1'b0, 13'h0111, 10'h020);
    wait_sb(0);
    // Refresh with a row open closes the bank
    refresh_req = 1'b1;
    push(CMD_PRECHARGE, 13'h0000, 0);
    wait_sb(0);
    tick(TRP + 1);
    check("open_refresh_ack", 32'(refresh_ack), 32'd1);
    refresh_req = 1'b0;
    tick(1);
`else
    // Back-to-back write then read: second ACT one cycle after TRP returns to IDLE
    push(CMD_ACTIVATE, 13'h1FFF, 0);
    push(CMD_WRITE, 13'h03FF, TRCD);
    push(CMD_PRECHARGE, 13'h0000, TRAS - TRCD);
    push(CMD_ACTIVATE, 13'h0000, TRP + 1);
    push(CMD_READ, 13'h0000, TRCD);
    push(CMD_PRECHARGE, 13'h0000, TRAS - TRCD);
    send_req(1'b1, 13'h1FFF, 10'h3FF);
    send_req(1'b0, 13'h0000, 10'h000);
    wait_sb(0);
    tick(TRP + 1);
`endif

    // Refresh and request together in IDLE: refresh wins
    refresh_req = 1'b1;
    req_valid   = 1'b1;
    req_row     = 13'h0777;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ref_idle_req_ready", 32'(req_ready), 32'd0);
      check("ref_idle_ack", 32'(refresh_ack), 32'd1);
    end
    @(posedge clk);
    #1;
    req_valid   = 1'b0;
    refresh_req = 1'b0;
    tick(1);

    // Refresh raised in TRCD: access completes, then PRE, then ack after T_RP
    push(CMD_ACTIVATE, 13'h00F0, 0);
    push(CMD_READ, 13'h0001, TRCD);
    push(CMD_PRECHARGE, 13'h0000, TRAS - TRCD);
    send_req(1'b0, 13'h00F0, 10'h001);
    wait_sb(2);
    refresh_req = 1'b1;
    wait_sb(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ref_ack_timing", 32'(refresh_ack), 32'((cyc - last_hs) >= TRP));
    end
    @(posedge clk);
    #1;
    refresh_req = 1'b0;
    tick(1);

    // cmd_ready stalled for 4 cycles in ACT: command held, tRCD from the handshake
    cmd_ready = 1'b0;
    push(CMD_ACTIVATE, 13'h0155, 0);
    push(CMD_READ, 13'h02AA, TRCD);
`ifndef DDR3_BANK_OPEN_PAGE_EN
    push(CMD_PRECHARGE, 13'h0000, TRAS - TRCD);
`endif
    send_req(1'b0, 13'h0155, 10'h2AA);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(cmd_valid), 32'd1);
      check("stall_type", 32'(cmd_type), 32'(CMD_ACTIVATE));
      check("stall_addr", 32'(cmd_addr), 32'h0155);
    end
    @(posedge clk);
    #1;
    cmd_ready = 1'b1;
    wait_sb(0);
    tick(TRP + 1);
`ifdef DDR3_BANK_OPEN_PAGE_EN
    refresh_req = 1'b1;
    push(CMD_PRECHARGE, 13'h0000, 0);
    wait_sb(0);
    tick(TRP + 1);
    refresh_req = 1'b0;
    tick(1);
`endif

    // Reset pulsed in TRCD: outputs drop at once and no READ follows
    push(CMD_ACTIVATE, 13'h0033, 0);
    send_req(1'b0, 13'h0033, 10'h005);
    wait_sb(0);
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    tick(2);
    rst = 1'b0;
    tick(12);
    check("post_rst_req_ready", 32'(req_ready), 32'd1);
    check("post_rst_sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
